// File: rtl/posit_act_pkg.sv
// Shared types and constants for the posit activation pipeline (es = 0).
// The mode encoding matches the s_mode_i port bit for bit.
package posit_act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS    = 2'b00,
        ACT_SIGMOID   = 2'b01,
        ACT_RELU      = 2'b10,
        ACT_SIGMOID_C = 2'b11
    } act_mode_e;

    // NaR is the sign bit alone: 1 followed by width-1 zeros.
    function automatic logic [31:0] nar_of(input int unsigned width);
        return 32'h1 << (width - 1);
    endfunction

endpackage

// File: rtl/posit_act_lane.sv
// Combinational activation for one posit lane (es = 0).
// Optional feature macro: POSIT_ACT_NAR_EN (NaR lanes pass through as NaR).
module posit_act_lane
    import posit_act_pkg::*;
#(
    parameter int POSIT_WIDTH = 16
) (
    input  logic [POSIT_WIDTH-1:0] posit,
    input  act_mode_e              mode,
    output logic [POSIT_WIDTH-1:0] result
);

    // Two's-complement negation feeds the complemented sigmoid: sigmoid(-x).
    logic [POSIT_WIDTH-1:0] neg;
    assign neg = -posit;

`ifdef POSIT_ACT_NAR_EN
    localparam logic [POSIT_WIDTH-1:0] NAR = POSIT_WIDTH'(nar_of(POSIT_WIDTH));
`endif

    // Mode select; the fast sigmoid flips the sign bit and shifts right by two.
    always_comb begin
        result = posit;
        case (mode)
            ACT_BYPASS:    result = posit;
            ACT_SIGMOID:   result = {~posit[POSIT_WIDTH-1], posit[POSIT_WIDTH-2:0]} >> 2;
            ACT_RELU:      result = posit[POSIT_WIDTH-1] ? '0 : posit;
            ACT_SIGMOID_C: result = {~neg[POSIT_WIDTH-1], neg[POSIT_WIDTH-2:0]} >> 2;
            default:       result = posit;
        endcase
`ifdef POSIT_ACT_NAR_EN
        if (posit == NAR) result = NAR;
`endif
    end

endmodule

// File: rtl/posit_activation_pipe.sv
// Multi-lane posit activation unit with a two-stage elastic pipeline.
// Optional feature macro: POSIT_ACT_NAR_EN (NaR propagation and NaR beat counter).
//
// Handshake: a beat moves across an interface in a cycle where valid and
// ready are both high at the rising edge. Once valid is raised it stays high
// and the payload stays stable until accepted. s_ready_o is combinational from
// m_ready_i (en2 = ~v2 | m_ready_i, en1 = ~v1 | en2, s_ready_o = en1).
module posit_activation_pipe
    import posit_act_pkg::*;
#(
    parameter int POSIT_WIDTH = 16,
    parameter int LANES       = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [1:0]                   s_mode_i,
    input  logic [LANES*POSIT_WIDTH-1:0] s_posit_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [LANES*POSIT_WIDTH-1:0] m_posit_o,
    output logic [CNT_WIDTH-1:0]         nar_count_o
);

    localparam int DW = LANES * POSIT_WIDTH;

    logic          v1, v2, en1, en2;
    act_mode_e     mode1;
    logic [DW-1:0] data1, data2, lane_out;

    assign en2       = ~v2 | m_ready_i;
    assign en1       = ~v1 | en2;
    assign s_ready_o = en1;
    assign m_valid_o = v2;
    assign m_posit_o = data2;

    // Stage 1 captures the raw lanes and the mode that travels with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mode1 <= ACT_BYPASS;
            data1 <= '0;
        end else if (en1) begin
            v1 <= s_valid_i;
            if (s_valid_i) begin
                mode1 <= act_mode_e'(s_mode_i);
                data1 <= s_posit_i;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        posit_act_lane #(
            .POSIT_WIDTH(POSIT_WIDTH)
        ) u_lane (
            .posit (data1[k*POSIT_WIDTH +: POSIT_WIDTH]),
            .mode  (mode1),
            .result(lane_out[k*POSIT_WIDTH +: POSIT_WIDTH])
        );
    end

    // Stage 2 holds computed lanes; it only loads when it is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            data2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) data2 <= lane_out;
        end
    end

`ifdef POSIT_ACT_NAR_EN
    localparam logic [POSIT_WIDTH-1:0] NAR = POSIT_WIDTH'(nar_of(POSIT_WIDTH));

    logic                 any_nar;
    logic [CNT_WIDTH-1:0] nar_count;

    // Flag an incoming beat that carries NaR in any lane.
    always_comb begin
        any_nar = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (s_posit_i[k*POSIT_WIDTH +: POSIT_WIDTH] == NAR) any_nar = 1'b1;
        end
    end

    // Saturating count of accepted NaR beats; clear wins over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nar_count <= '0;
        end else if (clear_i) begin
            nar_count <= '0;
        end else if (s_valid_i && en1 && any_nar && !(&nar_count)) begin
            nar_count <= nar_count + CNT_WIDTH'(1);
        end
    end

    assign nar_count_o = nar_count;
`else
    logic unused_clear;
    assign unused_clear = clear_i;
    assign nar_count_o  = '0;
`endif

endmodule

// File: tb/tb_posit_activation_pipe.sv
// Directed bench for posit_activation_pipe (W = 16, LANES = 4, CNT_WIDTH = 2).
// Expected lanes are written out by hand; the NaR-dependent ones follow
// whether POSIT_ACT_NAR_EN is defined for the build.
module tb_posit_activation_pipe;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int CW = 2;
    localparam int DW = W * L;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [1:0]    s_mode_i;
    logic [DW-1:0] s_posit_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_posit_o;
    logic [CW-1:0] nar_count_o;

    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_cnt = 0;

    // Directed vectors, lane 3 in the top 16 bits.
    localparam logic [DW-1:0] SIG_IN  = {16'h7FFF, 16'hC000, 16'h4000, 16'h0000};
    localparam logic [DW-1:0] SIG_EXP = {16'h3FFF, 16'h1000, 16'h3000, 16'h2000};
    localparam logic [DW-1:0] SGC_IN  = {16'hC000, 16'h7FFF, 16'h0000, 16'h4000};
    localparam logic [DW-1:0] SGC_EXP = {16'h3000, 16'h0000, 16'h2000, 16'h1000};
    localparam logic [DW-1:0] RLU_IN  = {16'h8001, 16'h7FFF, 16'h4000, 16'hC000};
    localparam logic [DW-1:0] RLU_EXP = {16'h0000, 16'h7FFF, 16'h4000, 16'h0000};
    localparam logic [DW-1:0] BYP_IN  = {16'h1234, 16'hABCD, 16'hFFFF, 16'h0001};
    localparam logic [DW-1:0] NAR_IN  = {16'h8000, 16'h4000, 16'h8000, 16'h0000};
    localparam logic [DW-1:0] ALL_NAR = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
`ifdef POSIT_ACT_NAR_EN
    localparam logic [DW-1:0] NAR_EXP   = {16'h8000, 16'h3000, 16'h8000, 16'h2000};
    localparam logic [DW-1:0] NAR_OTHER = ALL_NAR;
    localparam bit            CNT_ON    = 1'b1;
`else
    localparam logic [DW-1:0] NAR_EXP   = {16'h0000, 16'h3000, 16'h0000, 16'h2000};
    localparam logic [DW-1:0] NAR_OTHER = '0;
    localparam bit            CNT_ON    = 1'b0;
`endif
    localparam logic [DW-1:0] BP1_IN  = {16'h0000, 16'h4000, 16'hC000, 16'h7FFF};
    localparam logic [DW-1:0] BP1_EXP = {16'h2000, 16'h3000, 16'h1000, 16'h3FFF};
    localparam logic [DW-1:0] BP2_IN  = {16'h5000, 16'h3000, 16'h2000, 16'h1000};
    localparam logic [DW-1:0] BP2_EXP = {16'h3400, 16'h2C00, 16'h2800, 16'h2400};
    localparam logic [DW-1:0] BP3_IN  = {16'h0001, 16'hFFFF, 16'h7000, 16'h8001};
    localparam logic [DW-1:0] BP3_EXP = {16'h0001, 16'h0000, 16'h7000, 16'h0000};
    localparam logic [DW-1:0] BP4_IN  = {16'h1111, 16'h9999, 16'h2222, 16'hAAAA};
    localparam logic [DW-1:0] BP4_EXP = {16'h1111, 16'h0000, 16'h2222, 16'h0000};
    localparam logic [DW-1:0] BP5_IN  = {16'h0F0F, 16'hF0F0, 16'h7FFF, 16'h0000};
    localparam logic [DW-1:0] BP5_EXP = {16'h0F0F, 16'h0000, 16'h7FFF, 16'h0000};

    posit_activation_pipe #(
        .POSIT_WIDTH(W),
        .LANES      (L),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_mode_i   (s_mode_i),
        .s_posit_i  (s_posit_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_posit_o  (m_posit_o),
        .nar_count_o(nar_count_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: present one beat, wait (bounded) for acceptance, record expectation.
    task automatic send_beat(input logic [1:0] mode, input logic [DW-1:0] data,
                             input logic [DW-1:0] exp, input logic clr, input logic has_nar);
        bit accepted;
        accepted  = 1'b0;
        s_valid_i = 1'b1;
        s_mode_i  = mode;
        s_posit_i = data;
        clear_i   = clr;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (s_ready_o) accepted = 1'b1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready_o stayed 0 for 50 cycles, expected 1");
        end else begin
            exp_q.push_back(exp);
            if (CNT_ON) begin
                if (clr) exp_cnt = 0;
                else if (has_nar && exp_cnt < 3) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        clear_i   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: compare every beat handed downstream.
    always @(negedge clk) begin
        if (rst_n && m_valid_o && m_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat: got %h, expected no beat", m_posit_o);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_posit_o !== e) begin
                    errors++;
                    $display("FAIL out_beat: got %h expected %h", m_posit_o, e);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        clear_i   = 1'b0;
        s_valid_i = 1'b0;
        s_mode_i  = 2'b00;
        s_posit_i = '0;
        m_ready_i = 1'b1;

        // Reset state
        #3;
        check_val("rst_m_valid", DW'(m_valid_o), 0);
        check_val("rst_m_posit", m_posit_o, 0);
        check_val("rst_nar_count", DW'(nar_count_o), 0);
        check_val("rst_s_ready", DW'(s_ready_o), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sigmoid with latency check
        send_beat(2'b01, SIG_IN, SIG_EXP, 1'b0, 1'b0);
        @(negedge clk);
        check_val("lat_cycle1", DW'(m_valid_o), 0);
        @(negedge clk);
        check_val("lat_cycle2", DW'(m_valid_o), 1);
        drain();

        // Back-to-back beats, one per mode
        send_beat(2'b11, SGC_IN, SGC_EXP, 1'b0, 1'b0);
        send_beat(2'b10, RLU_IN, RLU_EXP, 1'b0, 1'b0);
        send_beat(2'b00, BYP_IN, BYP_IN, 1'b0, 1'b0);
        drain();

        // NaR handling and counting
        send_beat(2'b01, NAR_IN, NAR_EXP, 1'b0, 1'b1);
        @(negedge clk);
        check_val("nar_count_one", DW'(nar_count_o), DW'(exp_cnt));
        drain();

        // Clear in the same cycle as an accepted NaR beat
        send_beat(2'b01, NAR_IN, NAR_EXP, 1'b1, 1'b1);
        @(negedge clk);
        check_val("nar_count_clear", DW'(nar_count_o), 0);
        drain();

        // Saturation: five NaR beats into a 2-bit counter
        send_beat(2'b00, ALL_NAR, ALL_NAR, 1'b0, 1'b1);
        send_beat(2'b01, ALL_NAR, NAR_OTHER, 1'b0, 1'b1);
        send_beat(2'b10, ALL_NAR, NAR_OTHER, 1'b0, 1'b1);
        send_beat(2'b11, ALL_NAR, NAR_OTHER, 1'b0, 1'b1);
        send_beat(2'b00, ALL_NAR, ALL_NAR, 1'b0, 1'b1);
        @(negedge clk);
        check_val("nar_count_sat", DW'(nar_count_o), CNT_ON ? DW'(3) : DW'(0));
        drain();

        // Backpressure: downstream stalled for 4 cycles, mode change after beat 2
        m_ready_i = 1'b0;
        fork
            begin
                send_beat(2'b01, BP1_IN, BP1_EXP, 1'b0, 1'b0);
                send_beat(2'b01, BP2_IN, BP2_EXP, 1'b0, 1'b0);
                send_beat(2'b10, BP3_IN, BP3_EXP, 1'b0, 1'b0);
                send_beat(2'b10, BP4_IN, BP4_EXP, 1'b0, 1'b0);
                send_beat(2'b10, BP5_IN, BP5_EXP, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_val("bp_full_s_ready", DW'(s_ready_o), 0);
                check_val("bp_hold_valid", DW'(m_valid_o), 1);
                check_val("bp_hold_data", m_posit_o, BP1_EXP);
                repeat (2) @(posedge clk);
                #1 m_ready_i = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        m_ready_i = 1'b0;
        send_beat(2'b00, BYP_IN, BYP_IN, 1'b0, 1'b0);
        send_beat(2'b01, SIG_IN, SIG_EXP, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("midrst_m_valid", DW'(m_valid_o), 0);
        check_val("midrst_m_posit", m_posit_o, 0);
        check_val("midrst_nar_count", DW'(nar_count_o), 0);
        check_val("midrst_s_ready", DW'(s_ready_o), 1);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        send_beat(2'b11, SGC_IN, SGC_EXP, 1'b0, 1'b0);
        @(negedge clk);
        check_val("postrst_lat1", DW'(m_valid_o), 0);
        @(negedge clk);
        check_val("postrst_lat2", DW'(m_valid_o), 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
